// File: rtl/timer_pkg.sv
// Shared definitions for the timer/clock controller.
//   state_e   : mode encodings driven out on set_state
//   BEE_*     : buzzer command codes driven out on bee_in
//   CHIME_*   : minute/second values that trigger the hourly chime
//   bcd2bin() : two BCD digits to binary, for range compares
package timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BIN_W   = 7;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_MIN  = 2'b01,
        SET_HOUR = 2'b10
    } state_e;

    localparam logic [1:0] BEE_OFF   = 2'b00;
    localparam logic [1:0] BEE_SHORT = 2'b01;
    localparam logic [1:0] BEE_LONG  = 2'b10;

    // Short chime on even seconds 50..58 of minute 59; long tone at mm:ss 00:00
    localparam logic [DIGIT_W-1:0] CHIME_M1        = 4'd5;
    localparam logic [DIGIT_W-1:0] CHIME_M2        = 4'd9;
    localparam logic [BIN_W-1:0]   CHIME_SEC_FIRST = 7'd50;
    localparam logic [BIN_W-1:0]   CHIME_SEC_LAST  = 7'd58;

    function automatic logic [BIN_W-1:0] bcd2bin(input logic [DIGIT_W-1:0] tens,
                                                 input logic [DIGIT_W-1:0] units);
        return BIN_W'(tens) * 7'd10 + BIN_W'(units);
    endfunction

endpackage

// File: rtl/bcd_cnt.sv
// Two-digit BCD counter, 00..MAX, wrapping to 00.
//   clk, rst : clock, synchronous active-high reset
//   en       : advance by one on this edge
//   clr      : synchronous clear, wins over en
//   tens     : tens digit (registered)
//   units    : units digit (registered)
//   carry    : combinational, high when at MAX and enabled (wrap this edge)
module bcd_cnt
    import timer_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] MAX_TENS  = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_UNITS = DIGIT_W'(MAX % 10);

    logic at_max;

    assign at_max = (tens == MAX_TENS) && (units == MAX_UNITS);
    assign carry  = en && at_max;

    // BCD increment with wrap at MAX
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens  <= '0;
            units <= '0;
        end else if (en) begin
            if (at_max) begin
                tens  <= '0;
                units <= '0;
            end else if (units == 4'd9) begin
                tens  <= tens + 4'd1;
                units <= '0;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Digital clock controller: hh:mm:ss time keeping, mode FSM for setting
// minutes/hours, hourly chime and alarm with acknowledge.
//   clk, rst           : clock, synchronous active-high reset
//   tick_1hz           : 1 Hz enable pulse, advances time in RUN
//   tick_fast          : fast enable pulse, advances the field being set
//   mode_btn           : press pulse; cycles RUN->SET_MIN->SET_HOUR->RUN,
//                        or acknowledges a sounding alarm
//   clock_on           : alarm armed
//   clock_hour1..min2  : alarm time, BCD
//   h1,h2,m1,m2,s1,s2  : current time, BCD
//   set_state          : current mode
//   bee_in             : buzzer command (registered, lags counters by a cycle)
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CHIME_EN   = 1,
    parameter int unsigned ALARM_SECS = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_fast,
    input  logic               mode_btn,
    input  logic               clock_on,
    input  logic [DIGIT_W-1:0] clock_hour1,
    input  logic [DIGIT_W-1:0] clock_hour2,
    input  logic [DIGIT_W-1:0] clock_min1,
    input  logic [DIGIT_W-1:0] clock_min2,
    output logic [DIGIT_W-1:0] h1,
    output logic [DIGIT_W-1:0] h2,
    output logic [DIGIT_W-1:0] m1,
    output logic [DIGIT_W-1:0] m2,
    output logic [DIGIT_W-1:0] s1,
    output logic [DIGIT_W-1:0] s2,
    output logic [1:0]         set_state,
    output logic [1:0]         bee_in
);

    state_e           state, state_next;
    logic             alarm_ack, alarm_ack_next;
    logic [1:0]       bee_next;

    logic             in_run;
    logic             sec_en, sec_clr, sec_carry;
    logic             min_en, min_carry;
    logic             hr_en, hr_carry_unused;
    logic [BIN_W-1:0] sec_bin;
    logic             alarm_active, ack_press;
    logic             chime_short, chime_long;

    assign in_run = (state == RUN);

    // Counter enables: RUN cascades seconds->minutes->hours, SET modes use tick_fast
    assign sec_en  = in_run && tick_1hz;
    assign sec_clr = in_run && (state_next == SET_MIN);
    assign min_en  = (in_run && tick_1hz && sec_carry) || ((state == SET_MIN) && tick_fast);
    assign hr_en   = (in_run && tick_1hz && sec_carry && min_carry) ||
                     ((state == SET_HOUR) && tick_fast);

    bcd_cnt #(.MAX(59)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_en),
        .clr   (sec_clr),
        .tens  (s1),
        .units (s2),
        .carry (sec_carry)
    );

    bcd_cnt #(.MAX(59)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en),
        .clr   (1'b0),
        .tens  (m1),
        .units (m2),
        .carry (min_carry)
    );

    bcd_cnt #(.MAX(23)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .en    (hr_en),
        .clr   (1'b0),
        .tens  (h1),
        .units (h2),
        .carry (hr_carry_unused)
    );

    // Alarm/chime decode from the current counter values
    assign sec_bin      = bcd2bin(s1, s2);
    assign alarm_active = in_run && clock_on &&
                          ({h1, h2, m1, m2} == {clock_hour1, clock_hour2, clock_min1, clock_min2}) &&
                          (sec_bin < BIN_W'(ALARM_SECS));
    assign ack_press    = mode_btn && alarm_active && !alarm_ack;
    assign chime_short  = (CHIME_EN != 0) && in_run &&
                          (m1 == CHIME_M1) && (m2 == CHIME_M2) &&
                          (sec_bin >= CHIME_SEC_FIRST) && (sec_bin <= CHIME_SEC_LAST) &&
                          !sec_bin[0];
    assign chime_long   = (CHIME_EN != 0) && in_run &&
                          ({m1, m2, s1, s2} == '0);

    // State register, alarm acknowledge and buzzer command
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            alarm_ack <= 1'b0;
            bee_in    <= BEE_OFF;
        end else begin
            state     <= state_next;
            alarm_ack <= alarm_ack_next;
            bee_in    <= bee_next;
        end
    end

    // Next-state, acknowledge and buzzer decode
    always_comb begin
        state_next     = state;
        alarm_ack_next = alarm_ack;
        bee_next       = BEE_OFF;

        // A press that acknowledges the alarm is consumed and does not change mode
        unique case (state)
            RUN:      if (mode_btn && !ack_press) state_next = SET_MIN;
            SET_MIN:  if (mode_btn) state_next = SET_HOUR;
            SET_HOUR: if (mode_btn) state_next = RUN;
            default:  state_next = RUN;
        endcase

        // Minute change ends the alarm window, so the acknowledge is dropped with it
        if (!clock_on || min_en) begin
            alarm_ack_next = 1'b0;
        end else if (ack_press) begin
            alarm_ack_next = 1'b1;
        end

        // Silent as soon as the mode leaves RUN or the alarm is acknowledged
        if (in_run && (state_next == RUN)) begin
            if (chime_long) begin
                bee_next = BEE_LONG;
            end else if (chime_short) begin
                bee_next = BEE_SHORT;
            end else if (alarm_active && !alarm_ack && !ack_press) begin
                bee_next = BEE_LONG;
            end
        end
    end

    assign set_state = state;

endmodule
